// File: rtl/seg_pkg.sv
// Shared glyph table, FSM state encoding and BCD sizing helper for the display path.
// No logic here; latency and backpressure are properties of the modules that import it.
// Glyph bytes are {dp,g,f,e,d,c,b,a}, active high, dp never lit.
package seg_pkg;

    // Index n holds the glyph for hex digit n (0-9, A-F).
    localparam logic [15:0][7:0] GLYPH_HEX = {
        8'h71, 8'h79, 8'h5E, 8'h39, 8'h7C, 8'h77,
        8'h6F, 8'h7F, 8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
    };
    localparam logic [7:0] GLYPH_MINUS = 8'h40;
    localparam logic [7:0] GLYPH_R     = 8'h50;
    localparam logic [7:0] GLYPH_E     = 8'h79;
    localparam logic [7:0] GLYPH_BLANK = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CONVERT,
        ST_ENCODE,
        ST_SHIFT,
        ST_LATCH
    } state_e;

    // ceil(width * log10(2)) in integer arithmetic: decimal digits of 2^width-1.
    function automatic int bcd_digits(input int width);
        return (width * 30103 + 99999) / 100000;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: binary magnitude to packed BCD, one input bit per cycle.
// Latency: DATA_WIDTH cycles after start_i; done_o marks the cycle whose edge writes the final digit.
// Backpressure: none; a start_i restarts the conversion unconditionally.
module bin2bcd_seq
    import seg_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int BCD_DIGITS = bcd_digits(DATA_WIDTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_i,
    input  logic [DATA_WIDTH-1:0]   bin_i,
    output logic                    done_o,
    output logic [4*BCD_DIGITS-1:0] bcd_o
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam int BCD_W = 4 * BCD_DIGITS;

    logic [DATA_WIDTH-1:0] sh_q, sh_d;
    logic [BCD_W-1:0]      bcd_q, bcd_d, adj;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        sh_d  = sh_q;
        bcd_d = bcd_q;
        cnt_d = cnt_q;
        if (start_i) begin
            sh_d  = bin_i;
            bcd_d = '0;
            cnt_d = CNT_W'(DATA_WIDTH);
        end else if (cnt_q != '0) begin
            bcd_d = {adj[BCD_W-2:0], sh_q[DATA_WIDTH-1]};
            sh_d  = {sh_q[DATA_WIDTH-2:0], 1'b0};
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q  <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
        end else begin
            sh_q  <= sh_d;
            bcd_q <= bcd_d;
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == CNT_W'(1));
    assign bcd_o  = bcd_q;

endmodule

// File: rtl/seg_frame_driver.sv
// Converts a result to a 7-segment frame and shifts it into a 74HC595-style chain, then latches.
// Latency: (decimal ? DATA_WIDTH : 0) + 1 + 16*SR_CLK_DIV*NUM_DIGITS + SR_CLK_DIV cycles accept-to-ready.
// Backpressure: o_ready is high only in IDLE; i_valid is ignored while busy, nothing is queued.
module seg_frame_driver
    import seg_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_DIGITS = 5,
    parameter int SR_CLK_DIV = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_data_is_neg,
    input  logic                  i_error,
    input  logic                  i_hex_mode,
    input  logic                  i_valid,
    output logic                  o_ready,
    output logic                  o_sr_data,
    output logic                  o_sr_clk,
    output logic                  o_sr_latch
);

    localparam int BCDD  = bcd_digits(DATA_WIDTH);
    localparam int HEXD  = DATA_WIDTH / 4;
    localparam int MAXS  = (BCDD > HEXD) ? BCDD : HEXD;
    // Source digit vector is at least as wide as the display so every position indexes in range.
    localparam int SRCD  = (MAXS > NUM_DIGITS) ? MAXS : NUM_DIGITS;
    localparam int NBITS = 8 * NUM_DIGITS;
    localparam int PH_W  = $clog2(2 * SR_CLK_DIV);
    localparam int BIT_W = $clog2(NBITS);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  neg_q, neg_d, err_q, err_d, hex_q, hex_d;
    logic [NBITS-1:0]      frame_q, frame_d, enc_frame;
    logic [PH_W-1:0]       ph_q, ph_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic                  conv_start, conv_done;
    logic [4*BCDD-1:0]     bcd;
    logic [4*SRCD-1:0]     src;
    int                    sig;

    assign conv_start = (state_q == ST_IDLE) && i_valid && !i_hex_mode;

    bin2bcd_seq #(
        .DATA_WIDTH (DATA_WIDTH),
        .BCD_DIGITS (BCDD)
    ) u_bin2bcd (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (conv_start),
        .bin_i   (i_data),
        .done_o  (conv_done),
        .bcd_o   (bcd)
    );

    // Right-aligned, leading-zero-blanked frame; position 0 is the rightmost digit.
    always_comb begin
        src       = hex_q ? (4*SRCD)'(data_q) : (4*SRCD)'(bcd);
        sig       = 1;
        enc_frame = '0;
        for (int i = 0; i < SRCD; i++) begin
            if (src[4*i +: 4] != 4'd0) sig = i + 1;
        end
        if (err_q || (sig + int'(neg_q)) > NUM_DIGITS) begin
            enc_frame[23:0] = {GLYPH_E, GLYPH_R, GLYPH_R};
        end else begin
            for (int p = 0; p < NUM_DIGITS; p++) begin
                if (p < sig) begin
                    enc_frame[8*p +: 8] = GLYPH_HEX[src[4*p +: 4]];
                end else if (neg_q && p == sig) begin
                    enc_frame[8*p +: 8] = GLYPH_MINUS;
                end else begin
                    enc_frame[8*p +: 8] = GLYPH_BLANK;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        neg_d   = neg_q;
        err_d   = err_q;
        hex_d   = hex_q;
        frame_d = frame_q;
        ph_d    = ph_q;
        bit_d   = bit_q;
        case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    data_d  = i_data;
                    neg_d   = i_data_is_neg;
                    err_d   = i_error;
                    hex_d   = i_hex_mode;
                    state_d = i_hex_mode ? ST_ENCODE : ST_CONVERT;
                end
            end
            ST_CONVERT: begin
                if (conv_done) state_d = ST_ENCODE;
            end
            ST_ENCODE: begin
                frame_d = enc_frame;
                ph_d    = '0;
                bit_d   = '0;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (ph_q == PH_W'(2*SR_CLK_DIV - 1)) begin
                    ph_d    = '0;
                    frame_d = {frame_q[NBITS-2:0], 1'b0};
                    if (bit_q == BIT_W'(NBITS - 1)) begin
                        bit_d   = '0;
                        state_d = ST_LATCH;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end
            ST_LATCH: begin
                if (ph_q == PH_W'(SR_CLK_DIV - 1)) begin
                    ph_d    = '0;
                    state_d = ST_IDLE;
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            neg_q   <= 1'b0;
            err_q   <= 1'b0;
            hex_q   <= 1'b0;
            frame_q <= '0;
            ph_q    <= '0;
            bit_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            neg_q   <= neg_d;
            err_q   <= err_d;
            hex_q   <= hex_d;
            frame_q <= frame_d;
            ph_q    <= ph_d;
            bit_q   <= bit_d;
        end
    end

    // Outputs decode straight from flops so an async reset clears them at once.
    assign o_ready    = (state_q == ST_IDLE);
    assign o_sr_data  = (state_q == ST_SHIFT) && frame_q[NBITS-1];
    assign o_sr_clk   = (state_q == ST_SHIFT) && (ph_q >= PH_W'(SR_CLK_DIV));
    assign o_sr_latch = (state_q == ST_LATCH);

endmodule

// File: tb/tb_seg_frame_driver.sv
// Bench for seg_frame_driver: default instance (5 digits) plus a 4-digit instance for overflow.
module tb_seg_frame_driver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] data = '0;
    logic        neg = 1'b0, err = 1'b0, hex = 1'b0;
    logic        valid5 = 1'b0, valid4 = 1'b0;
    logic        rdy5, sd5, sc5, sl5, rdy4, sd4, sc4, sl4;
    logic        sel4 = 1'b0;
    logic        m_rdy, m_dat, m_clk, m_lat;

    int total = 0;
    int bad   = 0;

    logic [7:0] gl [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                            8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

    always #5 clk = ~clk;

    seg_frame_driver #(.DATA_WIDTH(16), .NUM_DIGITS(5), .SR_CLK_DIV(2)) dut5 (
        .clk(clk), .rst_n(rst_n), .i_data(data), .i_data_is_neg(neg), .i_error(err),
        .i_hex_mode(hex), .i_valid(valid5), .o_ready(rdy5), .o_sr_data(sd5),
        .o_sr_clk(sc5), .o_sr_latch(sl5));

    seg_frame_driver #(.DATA_WIDTH(16), .NUM_DIGITS(4), .SR_CLK_DIV(2)) dut4 (
        .clk(clk), .rst_n(rst_n), .i_data(data), .i_data_is_neg(neg), .i_error(err),
        .i_hex_mode(hex), .i_valid(valid4), .o_ready(rdy4), .o_sr_data(sd4),
        .o_sr_clk(sc4), .o_sr_latch(sl4));

    always_comb begin
        if (sel4) begin
            m_rdy = rdy4; m_dat = sd4; m_clk = sc4; m_lat = sl4;
        end else begin
            m_rdy = rdy5; m_dat = sd5; m_clk = sc5; m_lat = sl5;
        end
    end

    // Display as a string of digit values; e[0] is the leftmost digit.
    task automatic model(input int unsigned v, input bit n_i, input bit e_i, input bit h_i,
                         input int nd, output logic [7:0] e [8]);
        int          digs[$];
        int unsigned u;
        int unsigned base;
        base = h_i ? 16 : 10;
        u = v;
        do begin
            digs.push_back(int'(u % base));
            u = u / base;
        end while (u != 0);
        for (int i = 0; i < 8; i++) e[i] = 8'h00;
        if (e_i || (digs.size() + int'(n_i)) > nd) begin
            e[nd-3] = 8'h79; e[nd-2] = 8'h50; e[nd-1] = 8'h50;
        end else begin
            for (int i = 0; i < digs.size(); i++) e[nd-1-i] = gl[digs[i]];
            if (n_i) e[nd-1-digs.size()] = 8'h40;
        end
    endtask

    // Issues one request and observes the chain until ready returns; called just after a posedge.
    task automatic run_frame(input bit use4, input logic [15:0] d, input bit n_i, input bit e_i,
                             input bit h_i, input bit hold, input string name);
        logic [7:0] e [8];
        logic [7:0] b;
        bit         q[$];
        int         nd, n, lat_cyc, lat_pul, exp_lat;
        logic       pclk, plat;
        nd = use4 ? 4 : 5;
        model(int'(d), n_i, e_i, h_i, nd, e);
        exp_lat = (h_i ? 0 : 16) + 1 + 16 * 2 * nd + 2;
        sel4 = use4; data = d; neg = n_i; err = e_i; hex = h_i;
        if (use4) valid4 = 1'b1; else valid5 = 1'b1;
        @(posedge clk); #1;
        if (!hold) begin valid4 = 1'b0; valid5 = 1'b0; end
        total++;
        if (m_rdy !== 1'b0) begin
            bad++; $display("FAIL %s ready_drop: got %b want 0", name, m_rdy);
        end
        n = 0; pclk = 1'b0; plat = 1'b0; lat_cyc = 0; lat_pul = 0;
        while (m_rdy !== 1'b1 && n < 2000) begin
            if (m_clk === 1'b1 && pclk !== 1'b1) q.push_back(m_dat === 1'b1);
            if (m_lat === 1'b1) begin
                lat_cyc++;
                if (plat !== 1'b1) lat_pul++;
            end
            pclk = m_clk; plat = m_lat;
            @(posedge clk); #1; n++;
        end
        total++;
        if (n != exp_lat) begin
            bad++; $display("FAIL %s latency: got %0d want %0d", name, n, exp_lat);
        end
        total++;
        if (q.size() != 8 * nd) begin
            bad++; $display("FAIL %s bit_count: got %0d want %0d", name, q.size(), 8 * nd);
        end
        total++;
        if (lat_pul != 1 || lat_cyc != 2) begin
            bad++; $display("FAIL %s latch: got pulses=%0d cycles=%0d want 1/2", name, lat_pul, lat_cyc);
        end
        for (int k = 0; k < nd; k++) begin
            b = 8'hxx;
            if (q.size() >= 8 * (k + 1)) for (int j = 0; j < 8; j++) b = {b[6:0], q[8*k+j]};
            total++;
            if (b !== e[k]) begin
                bad++; $display("FAIL %s byte%0d: got %h want %h", name, k, b, e[k]);
            end
        end
        total++;
        if ({m_clk, m_dat, m_lat} !== 3'b000) begin
            bad++; $display("FAIL %s idle_outputs: got clk/dat/lat=%b want 000", name, {m_clk, m_dat, m_lat});
        end
    endtask

    task automatic test_reset();
        #12;
        total++;
        if ({rdy5, sd5, sc5, sl5, rdy4} !== 5'b10001) begin
            bad++; $display("FAIL reset_values: got rdy/dat/clk/lat/rdy4=%b want 10001", {rdy5, sd5, sc5, sl5, rdy4});
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({rdy5, sd5, sc5, sl5} !== 4'b1000) begin
            bad++; $display("FAIL post_reset: got %b want 1000", {rdy5, sd5, sc5, sl5});
        end
    endtask

    task automatic test_decimal();
        run_frame(0, 16'd1234, 0, 0, 0, 0, "dec_1234");
        run_frame(0, 16'd42,   1, 0, 0, 0, "dec_neg42");
        run_frame(0, 16'd0,    0, 0, 0, 0, "dec_zero");
        run_frame(0, 16'd0,    1, 0, 0, 0, "dec_negzero");
        run_frame(0, 16'd9999, 1, 0, 0, 0, "dec_neg9999_fits");
        run_frame(0, 16'd65535, 1, 0, 0, 0, "dec_neg65535_ovf");
    endtask

    task automatic test_error();
        run_frame(0, 16'd7,     0, 1, 0, 0, "err_flag");
        run_frame(1, 16'd65535, 0, 0, 0, 0, "ovf_4digit");
        run_frame(1, 16'd9999,  0, 0, 0, 0, "fit_4digit");
    endtask

    task automatic test_hex();
        run_frame(0, 16'hBEEF, 0, 0, 1, 0, "hex_beef");
        run_frame(0, 16'h00A0, 1, 0, 1, 0, "hex_neg_a0");
        run_frame(1, 16'hFFFF, 1, 0, 1, 0, "hex_4digit_ovf");
    endtask

    task automatic test_back_to_back();
        run_frame(0, 16'd815, 0, 0, 0, 1, "b2b_first");
        run_frame(0, 16'h1C3, 0, 0, 1, 1, "b2b_second");
        run_frame(0, 16'd77,  1, 0, 0, 0, "b2b_third");
    endtask

    task automatic test_random();
        logic [15:0] d;
        bit          n_r, e_r, h_r;
        for (int i = 0; i < 30; i++) begin
            d   = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 9999)) : 16'($urandom);
            n_r = 1'($urandom_range(0, 1));
            h_r = 1'($urandom_range(0, 1));
            e_r = ($urandom_range(0, 7) == 0);
            run_frame(i >= 24, d, n_r, e_r, h_r, 0, $sformatf("rand%0d", i));
        end
    endtask

    task automatic test_reset_mid_shift();
        int   rises, n, lat_seen, clk_seen;
        logic pclk;
        sel4 = 1'b0; data = 16'd1234; neg = 1'b0; err = 1'b0; hex = 1'b0; valid5 = 1'b1;
        @(posedge clk); #1; valid5 = 1'b0;
        rises = 0; n = 0; pclk = 1'b0;
        while (rises < 17 && n < 2000) begin
            @(posedge clk); #1; n++;
            if (sc5 === 1'b1 && pclk !== 1'b1) rises++;
            pclk = sc5;
        end
        total++;
        if (rises != 17) begin
            bad++; $display("FAIL rst_mid reach_bit17: got %0d rises want 17", rises);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({rdy5, sd5, sc5, sl5} !== 4'b1000) begin
            bad++; $display("FAIL rst_mid async_clear: got rdy/dat/clk/lat=%b want 1000", {rdy5, sd5, sc5, sl5});
        end
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        lat_seen = 0; clk_seen = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (sl5 !== 1'b0) lat_seen++;
            if (sc5 !== 1'b0) clk_seen++;
        end
        total++;
        if (rdy5 !== 1'b1) begin
            bad++; $display("FAIL rst_mid ready_after: got %b want 1", rdy5);
        end
        total++;
        if (lat_seen != 0 || clk_seen != 0) begin
            bad++; $display("FAIL rst_mid no_pulse: got latch=%0d clk=%0d cycles want 0/0", lat_seen, clk_seen);
        end
        run_frame(0, 16'd1234, 0, 0, 0, 0, "rst_mid_recover");
    endtask

    initial begin
        test_reset();
        test_decimal();
        test_error();
        test_hex();
        test_back_to_back();
        test_random();
        test_reset_mid_shift();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg_frame_driver.md
# seg_frame_driver

Parametrised successor to the calculator's display output path. Takes a result (magnitude, sign flag, error flag) over a valid/ready handshake and converts it to 7-segment glyphs in decimal (double-dabble) or hex. It shifts the frame out serially to a daisy-chained 74HC595-style register chain, then pulses the latch. It sits between calculator_core and the external display board, and supports any digit count, data width and shift-clock rate.

## Interface
- DATA_WIDTH, 16, magnitude width in bits (≥4, multiple of 4)
- NUM_DIGITS, 5, number of 7-segment digits in the chain (≥3)
- SR_CLK_DIV, 2, system cycles per half-period of o_sr_clk (≥1)
- clk  input  1  system clock; the block uses this one clock only.
- rst_n  input  1  reset, asynchronous and active-low.
- i_data  input  DATA_WIDTH  unsigned magnitude to display
- i_data_is_neg  input  1  prefix a minus sign
- i_error  input  1  show "Err"; overrides i_data and i_data_is_neg
- i_hex_mode  input  1  1 = hex digits, 0 = decimal
- i_valid  input  1  request valid
- o_ready  output  1  block idle, can accept a request
- o_sr_data  output  1  serial data, MSB first
- o_sr_clk  output  1  shift clock, rising-edge sampled by the chain
- o_sr_latch  output  1  storage-register latch pulse, active high

## Operation
- Reset values: o_ready=1, o_sr_data=0, o_sr_clk=0, o_sr_latch=0, FSM=IDLE.
- Accept on i_valid && o_ready. All inputs are captured in that cycle. i_valid is ignored while o_ready=0 (no queueing).
- FSM: IDLE → CONVERT (decimal only) → ENCODE → SHIFT → LATCH → IDLE.
- CONVERT: double-dabble over exactly DATA_WIDTH cycles into a BCD register of ceil(DATA_WIDTH·log10(2)) digits.
- ENCODE: one cycle. Builds the NUM_DIGITS×8-bit frame.
- Glyph byte is {dp,g,f,e,d,c,b,a}, active high, dp always 0.
  - 0–9 glyphs: 3F 06 5B 4F 66 6D 7D 07 7F 6F
  - A–F glyphs: 77 7C 39 5E 79 71
  - minus 40, "r" 50, blank 00
- Numbers are right-aligned. Leading zeros are blanked; value 0 shows a single "0".
- Minus goes in the position immediately left of the most significant non-blank digit.
- Overflow: if significant digits + sign exceed NUM_DIGITS, display "Err".
- Error: frame is "Err", right-aligned (79 50 50), with all other positions blank.
- SHIFT: emits NUM_DIGITS·8 bits, leftmost digit first, byte MSB first.
- LATCH: raises o_sr_latch for SR_CLK_DIV cycles, then returns to IDLE.

## Timing
- Per bit: o_sr_data is set at bit start and held 2·SR_CLK_DIV cycles. o_sr_clk is low for the first SR_CLK_DIV cycles and high for the next SR_CLK_DIV.
- o_sr_clk is low whenever the FSM is not in SHIFT. o_sr_data returns to 0 after SHIFT.
- Latency from the accept cycle to o_ready=1:
  - (decimal ? DATA_WIDTH : 0) + 1 + 16·SR_CLK_DIV·NUM_DIGITS + SR_CLK_DIV cycles.
  - Example, defaults in decimal: 16 + 1 + 160 + 2 = 179 cycles.
- o_ready drops the cycle after accept. A new request can be accepted in the first IDLE cycle; there are no dead cycles.
- Asynchronous reset mid-operation: all outputs go to their reset values immediately and the partial frame is discarded. No latch pulse is emitted.

## Structure
- Shared package seg_pkg holds:
  - the glyph constants (digits 0–F, minus, r, blank)
  - the state enum
  - the function bcd_digits(width)
- Natural sub-module: bin2bcd_seq, the sequential double-dabble converter with start/done. The encode/shift FSM stays in seg_frame_driver.
- Expected size is about 250 lines including the sub-module.

## Test plan
- Defaults, decimal, i_data=1234 → five bytes shifted: 00 06 5B 4F 66; one latch pulse; latency 179 cycles.
- Decimal, i_data=42, i_data_is_neg=1 → 00 00 40 66 5B.
- i_error=1 with i_data=7 → 00 00 79 50 50. Same result for NUM_DIGITS=4 with i_data=65535, decimal (overflow).
- Hex mode, i_data=16'hBEEF → 00 7C 79 79 71; latency 1+160+2=163 cycles.
- i_data=0, decimal → 00 00 00 00 3F. Also: i_valid held high while busy → exactly one frame; next frame accepted in the first IDLE cycle.
- Assert rst_n low at bit 17 of SHIFT → o_sr_clk, o_sr_data and o_sr_latch go to 0 asynchronously; o_ready=1 after release; no latch pulse ever seen.
